// File: rtl/fp_compare_pipe.sv
// Two-stage floating-point compare / min / max pipeline, with a streaming
// reduction max (RMAX) that reports the position of the first maximum.
module fp_compare_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned IDX_W = 8
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1+EXP_W+MAN_W-1:0]     a_operand,
    input  logic [1+EXP_W+MAN_W-1:0]     b_operand,
    input  logic [2:0]                   mode,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1+EXP_W+MAN_W-1:0]     result,
    output logic                         flag,
    output logic                         unordered,
    output logic [IDX_W-1:0]             idx
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] MODE_LT   = 3'b001;
    localparam logic [2:0] MODE_EQ   = 3'b010;
    localparam logic [2:0] MODE_MIN  = 3'b011;
    localparam logic [2:0] MODE_MAX  = 3'b100;
    localparam logic [2:0] MODE_RMAX = 3'b101;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic is_zero(input logic [W-1:0] x);
        return ~|x[W-2:0];
    endfunction

    // Ordered greater-than on non-NaN values; signed zeros are equal
    function automatic logic fp_gt(input logic [W-1:0] x, input logic [W-1:0] y);
        if (is_zero(x) && is_zero(y))
            return 1'b0;
        if (x[W-1] != y[W-1])
            return ~x[W-1];
        if (!x[W-1])
            return x[W-2:0] > y[W-2:0];
        return x[W-2:0] < y[W-2:0];
    endfunction

    // Stage-1 registers
    logic             s1_valid;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [2:0]       s1_mode;
    logic             s1_a_nan;
    logic             s1_b_nan;
    logic             s1_a_zero;
    logic             s1_b_zero;
    logic             s1_gt;
    logic             s1_lt;
    logic             s1_eq;
    logic [IDX_W-1:0] s1_ridx;
    logic             s1_runord;

    // Reduction state
    logic [W-1:0]     acc;
    logic             acc_open;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] best_idx;
    logic             sticky;

    logic             advance;
    logic             accept;
    logic             is_rmax;
    logic             x_nan;
    logic [W-1:0]     f_acc;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] f_cnt;
    logic             f_sticky;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;
    assign is_rmax  = (mode == MODE_RMAX);
    assign x_nan    = is_nan(a_operand);

    // Fold the incoming RMAX beat into the accumulator
    always_comb begin
        f_acc    = acc;
        f_idx    = best_idx;
        f_sticky = sticky;
        f_cnt    = cnt + IDX_W'(1);
        if (!acc_open) begin
            f_acc    = a_operand;
            f_idx    = '0;
            f_sticky = x_nan;
            f_cnt    = IDX_W'(1);
        end else begin
            if (!x_nan && (is_nan(acc) || fp_gt(a_operand, acc))) begin
                f_acc = a_operand;
                f_idx = cnt;
            end
            f_sticky = sticky | x_nan;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc      <= '0;
            acc_open <= 1'b0;
            cnt      <= '0;
            best_idx <= '0;
            sticky   <= 1'b0;
        end else if (accept && is_rmax) begin
            acc      <= f_acc;
            acc_open <= ~in_last;
            cnt      <= f_cnt;
            best_idx <= f_idx;
            sticky   <= f_sticky;
        end
    end

    // Stage 1: classify and compare; non-last RMAX beats leave no bubble behind
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_mode   <= '0;
            s1_a_nan  <= 1'b0;
            s1_b_nan  <= 1'b0;
            s1_a_zero <= 1'b0;
            s1_b_zero <= 1'b0;
            s1_gt     <= 1'b0;
            s1_lt     <= 1'b0;
            s1_eq     <= 1'b0;
            s1_ridx   <= '0;
            s1_runord <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid & ~(is_rmax & ~in_last);
            if (in_valid) begin
                s1_a      <= is_rmax ? f_acc : a_operand;
                s1_b      <= b_operand;
                s1_mode   <= mode;
                s1_a_nan  <= x_nan;
                s1_b_nan  <= is_nan(b_operand);
                s1_a_zero <= is_zero(a_operand);
                s1_b_zero <= is_zero(b_operand);
                s1_gt     <= fp_gt(a_operand, b_operand);
                s1_lt     <= fp_gt(b_operand, a_operand);
                s1_eq     <= (is_zero(a_operand) && is_zero(b_operand)) || (a_operand == b_operand);
                s1_ridx   <= f_idx;
                s1_runord <= f_sticky;
            end
        end
    end

    logic             any_nan;
    logic [W-1:0]     n_result;
    logic             n_flag;
    logic             n_unord;
    logic [IDX_W-1:0] n_idx;

    assign any_nan = s1_a_nan | s1_b_nan;

    // Stage 2 select
    always_comb begin
        n_result = '0;
        n_flag   = 1'b0;
        n_unord  = 1'b0;
        n_idx    = '0;
        if (s1_valid) begin
            case (s1_mode)
                MODE_LT: begin
                    n_flag  = ~any_nan & s1_lt;
                    n_unord = any_nan;
                end
                MODE_EQ: begin
                    n_flag  = ~any_nan & s1_eq;
                    n_unord = any_nan;
                end
                MODE_MIN, MODE_MAX: begin
                    n_unord = any_nan;
                    if (s1_a_nan && s1_b_nan)
                        n_result = QNAN;
                    else if (s1_a_nan)
                        n_result = s1_b;
                    else if (s1_b_nan)
                        n_result = s1_a;
                    else if (s1_a_zero && s1_b_zero)
                        n_result = ((s1_mode == MODE_MIN) == s1_a[W-1]) ? s1_a : s1_b;
                    else if (s1_mode == MODE_MIN)
                        n_result = s1_gt ? s1_b : s1_a;
                    else
                        n_result = s1_lt ? s1_b : s1_a;
                end
                MODE_RMAX: begin
                    n_result = s1_a;
                    n_idx    = s1_ridx;
                    n_unord  = s1_runord;
                end
                default: begin
                    n_flag  = ~any_nan & s1_gt;
                    n_unord = any_nan;
                end
            endcase
        end
    end

    // Stage 2: output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag      <= 1'b0;
            unordered <= 1'b0;
            idx       <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            result    <= n_result;
            flag      <= n_flag;
            unordered <= n_unord;
            idx       <= n_idx;
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Scoreboard bench for fp_compare_pipe: driver queues expected outputs on
// accept, an independent monitor checks them as the DUT delivers them.
`timescale 1ns/1ps
module tb_fp_compare_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [2:0]  mode;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag;
    logic        unordered;
    logic [7:0]  idx;

    fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .IDX_W(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_operand), .b_operand(b_operand),
        .mode(mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag(flag), .unordered(unordered), .idx(idx)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        flg;
        logic        unord;
        logic [7:0]  ix;
        int          out_cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   n_acc = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (!RESET && out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got res=0x%08h flag=%0b unord=%0b idx=%0d, expected none",
                             result, flag, unordered, idx);
                end else begin
                    e = q.pop_front();
                    if (result !== e.res || flag !== e.flg || unordered !== e.unord || idx !== e.ix) begin
                        fails++;
                        $display("FAIL %s: got res=0x%08h flag=%0b unord=%0b idx=%0d, expected res=0x%08h flag=%0b unord=%0b idx=%0d",
                                 e.nm, result, flag, unordered, idx, e.res, e.flg, e.unord, e.ix);
                    end
                    if (e.out_cyc >= 0) begin
                        tests++;
                        if (cyc != e.out_cyc) begin
                            fails++;
                            $display("FAIL %s_latency: got cycle %0d, expected cycle %0d", e.nm, cyc, e.out_cyc);
                        end
                    end
                end
            end
        end
    end

    // Offer one beat at a negedge; returns at the following negedge after it is accepted
    task automatic send(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] m, input logic last, input bit has_out,
                        input logic [31:0] er, input logic ef, input logic eu,
                        input logic [7:0] ei, input bit lat);
        exp_t e;
        int n;
        in_valid  = 1'b1;
        a_operand = a;
        b_operand = b;
        mode      = m;
        in_last   = last;
        n = 0;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept_timeout: got in_ready=0, expected 1", nm);
        end else begin
            n_acc++;
            if (has_out) begin
                e.nm = nm; e.res = er; e.flg = ef; e.unord = eu; e.ix = ei;
                e.out_cyc = lat ? cyc + 2 : -1;
                q.push_back(e);
            end
            @(posedge CLK);
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    localparam logic [2:0] GT = 3'd0, LT = 3'd1, EQ = 3'd2, MN = 3'd3, MX = 3'd4, RM = 3'd5;

    initial begin
        int base;
        RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_operand = '0; b_operand = '0; mode = '0; in_last = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    result,         32'd0);
        chk("rst_flags",     {29'd0, flag, unordered, 1'b0} | 32'(idx), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic compares, back-to-back
        send("gt_equal",  32'h41200000, 32'h41200000, GT, 0, 1, 32'h0, 0, 0, 8'd0, 1);
        send("eq_equal",  32'h41200000, 32'h41200000, EQ, 0, 1, 32'h0, 1, 0, 8'd0, 1);
        send("eq_zeros",  32'h80000000, 32'h00000000, EQ, 0, 1, 32'h0, 1, 0, 8'd0, 1);
        send("min_zeros", 32'h80000000, 32'h00000000, MN, 0, 1, 32'h80000000, 0, 0, 8'd0, 1);
        send("max_zeros", 32'h80000000, 32'h00000000, MX, 0, 1, 32'h00000000, 0, 0, 8'd0, 1);
        send("gt_nan",    32'h7FC00000, 32'h3F800000, GT, 0, 1, 32'h0, 0, 1, 8'd0, 1);
        send("max_nan",   32'h7FC00000, 32'h3F800000, MX, 0, 1, 32'h3F800000, 0, 1, 8'd0, 1);
        send("lt_signs",  32'hBF800000, 32'h3F800000, LT, 0, 1, 32'h0, 1, 0, 8'd0, 1);
        send("min_2nan",  32'h7FC00000, 32'hFF800001, MN, 0, 1, 32'h7FC00000, 0, 1, 8'd0, 1);
        send("gt_mode7",  32'h3F800000, 32'hBF800000, 3'd7, 0, 1, 32'h0, 1, 0, 8'd0, 1);
        send("lt_ninf",   32'hFF800000, 32'hBF800000, LT, 0, 1, 32'h0, 1, 0, 8'd0, 1);
        send("max_negs",  32'hC0000000, 32'hBF800000, MX, 0, 1, 32'hBF800000, 0, 0, 8'd0, 1);
        send("min_eq_a",  32'h40000000, 32'h40000000, MN, 0, 1, 32'h40000000, 0, 0, 8'd0, 1);
        drain();

        // Back-pressure: 6 stalled cycles while 3 beats are offered
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                send("stall_gt",  32'h40000000, 32'h3F800000, GT, 0, 1, 32'h0, 1, 0, 8'd0, 0);
                send("stall_lt",  32'h3F800000, 32'h40000000, LT, 0, 1, 32'h0, 1, 0, 8'd0, 0);
                send("stall_max", 32'h3F800000, 32'h40000000, MX, 0, 1, 32'h40000000, 0, 0, 8'd0, 0);
            end
            begin
                repeat (5) @(negedge CLK);
                #3;
                chk("stall_accepts",  32'(n_acc - base), 32'd2);
                chk("stall_in_ready", 32'(in_ready),     32'd0);
                @(negedge CLK);
                out_ready = 1'b1;
            end
        join
        drain();

        // RMAX with an interleaved ordinary beat
        send("rmax_b0", 32'h3F800000, 32'h0, RM, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        send("rmax_b1", 32'h40A00000, 32'h0, RM, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        send("rmax_mid_gt", 32'h40A00000, 32'h3F800000, GT, 0, 1, 32'h0, 1, 0, 8'd0, 1);
        send("rmax_b2", 32'hC0000000, 32'h0, RM, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        send("rmax_tie", 32'h40A00000, 32'h0, RM, 1, 1, 32'h40A00000, 0, 0, 8'd1, 1);
        drain();

        // RMAX with a NaN beat
        send("rnan_b0", 32'h3F800000, 32'h0, RM, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        send("rnan_b1", 32'h7FC00000, 32'h0, RM, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        send("rmax_nan", 32'h40000000, 32'h0, RM, 1, 1, 32'h40000000, 0, 1, 8'd2, 1);
        drain();

        // Reset mid-reduction with an ordinary beat in flight
        send("rst_b0", 32'h40A00000, 32'h0, RM, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        send("rst_b1", 32'h40E00000, 32'h0, RM, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        send("rst_inflight", 32'h40000000, 32'h3F800000, GT, 0, 0, 32'h0, 0, 0, 8'd0, 1);
        RESET = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        send("rmax_single", 32'h40000000, 32'h0, RM, 1, 1, 32'h40000000, 0, 0, 8'd0, 1);
        drain();
        repeat (5) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
